// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control path: state codes, opcodes,
// ALU/mux select values and the control bundle type.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       branch;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // States whose exit to FETCH retires an instruction.
  function automatic logic is_final(state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTWB) ||
           (s == S_BEQEX) || (s == S_ADDIWB) || (s == S_JEX);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output table: maps the current state to raw datapath controls,
// before any memory-wait gating applied by the top level.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JEX: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control FSM: sequencing, memory-wait stalls,
// store/load tracking, retire pulse and retired-instruction counter.
module multicycle_control_fsm
  import mc_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int STATE_W       = 4,
  parameter int USE_MEM_READY = 1,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic [STATE_W-1:0]  state,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic                branch,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired
);

  state_e     state_q, state_d, dec_state;
  logic       is_store_q;
  logic [5:0] op;
  logic       mem_ok, wait_hold, retire;
  ctrl_t      ctrl;

  assign op     = 6'(opcode);
  assign mem_ok = (USE_MEM_READY == 0) || mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_RTEX;
        else if (op == OP_BEQ)          state_d = S_BEQEX;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JEX;
        else                            state_d = S_TRAP;
      end
      // Opcode may have changed since DECODE, so use the captured direction.
      S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  assign retire = is_final(state_q) && (state_d == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q <= 1'b0;
      instr_done <= 1'b0;
      retired    <= '0;
    end else begin
      if (state_q == S_DECODE) is_store_q <= (op == OP_SW);
      instr_done <= retire;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Reset presents FETCH controls with the state-changing strobes suppressed.
  assign dec_state = rst ? S_FETCH : state_q;

  mc_ctrl_decode u_decode (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  always_comb begin
    wait_hold  = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                  (state_q == S_MEMWR)) && !mem_ok;
    pc_write   = ctrl.pc_write && !wait_hold && !rst;
    ir_write   = ctrl.ir_write && !wait_hold && !rst;
    mem_write  = ctrl.mem_write && !wait_hold;
    mem_read   = ctrl.mem_read;
    iord       = ctrl.iord;
    reg_write  = ctrl.reg_write;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    alu_src_a  = ctrl.alu_src_a;
    branch     = ctrl.branch;
    alu_src_b  = ctrl.alu_src_b;
    alu_op     = ctrl.alu_op;
    pc_src     = ctrl.pc_src;
  end

  assign state      = STATE_W'(state_q);
  assign illegal_op = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: default instance for sequencing,
// stalls, trap and reset; a 4-bit-counter no-wait instance for wrap-around.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        rst, mem_ready;
  logic [5:0]  opcode;
  logic [3:0]  state;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, branch, instr_done, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [31:0] retired;

  logic        rst2, mem_ready2;
  logic [5:0]  opcode2;
  logic [3:0]  state2;
  logic        pc_write2, ir_write2, mem_read2, mem_write2, iord2, reg_write2;
  logic        reg_dst2, mem_to_reg2, alu_src_a2, branch2, instr_done2, illegal_op2;
  logic [1:0]  alu_src_b2, alu_op2, pc_src2;
  logic [3:0]  retired2;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .state(state),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .branch(branch),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
  );

  multicycle_control_fsm #(.USE_MEM_READY(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode2), .mem_ready(mem_ready2), .state(state2),
    .pc_write(pc_write2), .ir_write(ir_write2), .mem_read(mem_read2),
    .mem_write(mem_write2), .iord(iord2), .reg_write(reg_write2), .reg_dst(reg_dst2),
    .mem_to_reg(mem_to_reg2), .alu_src_a(alu_src_a2), .branch(branch2),
    .alu_src_b(alu_src_b2), .alu_op(alu_op2), .pc_src(pc_src2),
    .instr_done(instr_done2), .illegal_op(illegal_op2), .retired(retired2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    #0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst2 = 1'b1;
    opcode2 = 6'h08;
    mem_ready2 = 1'b0;

    // Reset cycle: FETCH controls with pc/ir writes suppressed
    applyStimulus(1'b1, 6'h00, 1'b1);
    tick();
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_illegal", 32'(illegal_op), 0);
    checkOutput("rst_done", 32'(instr_done), 0);
    checkOutput("rst_memread", 32'(mem_read), 1);
    checkOutput("rst_pcwrite", 32'(pc_write), 0);
    checkOutput("rst_irwrite", 32'(ir_write), 0);
    checkOutput("rst_srcb", 32'(alu_src_b), 1);

    // LW, opcode switched to SW after DECODE to prove is_store is used
    applyStimulus(1'b0, 6'h23, 1'b1);
    checkOutput("lw_fetch_pcw", 32'(pc_write), 1);
    checkOutput("lw_fetch_irw", 32'(ir_write), 1);
    tick();
    checkOutput("lw_decode", 32'(state), 1);
    checkOutput("lw_decode_srcb", 32'(alu_src_b), 3);
    tick();
    checkOutput("lw_memadr", 32'(state), 2);
    applyStimulus(1'b0, 6'h2B, 1'b1);
    checkOutput("lw_memadr_srca", 32'(alu_src_a), 1);
    checkOutput("lw_memadr_srcb", 32'(alu_src_b), 2);
    tick();
    checkOutput("lw_memrd", 32'(state), 3);
    checkOutput("lw_memrd_iord", 32'(iord), 1);
    checkOutput("lw_memrd_rd", 32'(mem_read), 1);
    tick();
    checkOutput("lw_memwb", 32'(state), 4);
    checkOutput("lw_memwb_rw", 32'(reg_write), 1);
    checkOutput("lw_memwb_m2r", 32'(mem_to_reg), 1);
    checkOutput("lw_memwb_done", 32'(instr_done), 0);
    tick();
    checkOutput("lw_end_state", 32'(state), 0);
    checkOutput("lw_end_done", 32'(instr_done), 1);
    checkOutput("lw_end_retired", retired, 1);

    // SW with three wait cycles in MEMWR, opcode switched to LW after DECODE
    applyStimulus(1'b0, 6'h2B, 1'b1);
    tick();
    checkOutput("sw_decode", 32'(state), 1);
    checkOutput("sw_done_one_cycle", 32'(instr_done), 0);
    tick();
    checkOutput("sw_memadr", 32'(state), 2);
    applyStimulus(1'b0, 6'h23, 1'b0);
    tick();
    checkOutput("sw_memwr", 32'(state), 5);
    checkOutput("sw_wait_mw0", 32'(mem_write), 0);
    checkOutput("sw_wait_iord", 32'(iord), 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("sw_wait_state", 32'(state), 5);
      checkOutput("sw_wait_mw", 32'(mem_write), 0);
    end
    applyStimulus(1'b0, 6'h23, 1'b1);
    checkOutput("sw_adv_mw", 32'(mem_write), 1);
    checkOutput("sw_adv_state", 32'(state), 5);
    tick();
    checkOutput("sw_end_state", 32'(state), 0);
    checkOutput("sw_end_done", 32'(instr_done), 1);
    checkOutput("sw_end_retired", retired, 2);

    // FETCH stall: read held, strobes only on the advancing cycle
    applyStimulus(1'b0, 6'h23, 1'b0);
    checkOutput("fstall_rd", 32'(mem_read), 1);
    checkOutput("fstall_pcw", 32'(pc_write), 0);
    checkOutput("fstall_irw", 32'(ir_write), 0);
    tick();
    checkOutput("fstall_state", 32'(state), 0);
    checkOutput("fstall_done", 32'(instr_done), 0);
    checkOutput("fstall_retired", retired, 2);

    // Illegal opcode traps for 10 cycles until reset
    applyStimulus(1'b0, 6'h3F, 1'b1);
    checkOutput("trap_fetch_pcw", 32'(pc_write), 1);
    tick();
    checkOutput("trap_decode", 32'(state), 1);
    tick();
    checkOutput("trap_state", 32'(state), 12);
    checkOutput("trap_illegal", 32'(illegal_op), 1);
    for (int k = 0; k < 9; k++) begin
      tick();
      checkOutput("trap_hold_state", 32'(state), 12);
      checkOutput("trap_hold_illegal", 32'(illegal_op), 1);
      checkOutput("trap_hold_rd", 32'(mem_read), 0);
    end
    checkOutput("trap_done", 32'(instr_done), 0);
    checkOutput("trap_retired", retired, 2);
    applyStimulus(1'b1, 6'h3F, 1'b1);
    tick();
    checkOutput("trap_rst_state", 32'(state), 0);
    checkOutput("trap_rst_illegal", 32'(illegal_op), 0);
    checkOutput("trap_rst_retired", retired, 0);

    // BEQ then J back to back
    applyStimulus(1'b0, 6'h04, 1'b1);
    tick();
    checkOutput("beq_decode", 32'(state), 1);
    tick();
    checkOutput("beq_ex", 32'(state), 8);
    checkOutput("beq_pcsrc", 32'(pc_src), 1);
    checkOutput("beq_branch", 32'(branch), 1);
    checkOutput("beq_aluop", 32'(alu_op), 1);
    applyStimulus(1'b0, 6'h02, 1'b1);
    tick();
    checkOutput("beq_end_state", 32'(state), 0);
    checkOutput("beq_end_retired", retired, 1);
    checkOutput("beq_end_done", 32'(instr_done), 1);
    tick();
    checkOutput("j_decode", 32'(state), 1);
    tick();
    checkOutput("j_ex", 32'(state), 11);
    checkOutput("j_pcsrc", 32'(pc_src), 2);
    checkOutput("j_pcw", 32'(pc_write), 1);
    tick();
    checkOutput("j_end_state", 32'(state), 0);
    checkOutput("j_end_retired", retired, 2);
    checkOutput("j_end_done", 32'(instr_done), 1);

    // RTYPE aborted by reset in RTEX, then a full RTYPE
    applyStimulus(1'b1, 6'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 6'h00, 1'b1);
    checkOutput("rt_pre_retired", retired, 0);
    tick();
    tick();
    checkOutput("rt_ex", 32'(state), 6);
    checkOutput("rt_ex_aluop", 32'(alu_op), 2);
    checkOutput("rt_ex_rw", 32'(reg_write), 0);
    applyStimulus(1'b1, 6'h00, 1'b1);
    checkOutput("rt_rst_rw", 32'(reg_write), 0);
    tick();
    checkOutput("rt_rst_state", 32'(state), 0);
    checkOutput("rt_rst_retired", retired, 0);
    checkOutput("rt_rst_done", 32'(instr_done), 0);
    applyStimulus(1'b0, 6'h00, 1'b1);
    checkOutput("rt_post_rw", 32'(reg_write), 0);
    tick();
    tick();
    tick();
    checkOutput("rt_wb", 32'(state), 7);
    checkOutput("rt_wb_rw", 32'(reg_write), 1);
    checkOutput("rt_wb_dst", 32'(reg_dst), 1);
    tick();
    checkOutput("rt_end_state", 32'(state), 0);
    checkOutput("rt_end_retired", retired, 1);

    // 17 ADDIs on the 4-bit counter, no-wait instance with mem_ready low
    rst2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      checkOutput("addi_decode", 32'(state2), 1);
      tick();
      checkOutput("addi_ex", 32'(state2), 9);
      if (i == 0) begin
        checkOutput("addi_ex_srca", 32'(alu_src_a2), 1);
        checkOutput("addi_ex_srcb", 32'(alu_src_b2), 2);
      end
      tick();
      checkOutput("addi_wb", 32'(state2), 10);
      if (i == 0) checkOutput("addi_wb_rw", 32'(reg_write2), 1);
      tick();
      checkOutput("addi_retired", 32'(retired2), 32'((i + 1) % 16));
    end
    checkOutput("addi_wrap", 32'(retired2), 1);
    checkOutput("addi_end_state", 32'(state2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6: opcode field width.
REQ-002 SHALL have parameter STATE_W, default 4: state encoding width, minimum 4.
REQ-003 SHALL have parameter USE_MEM_READY, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready ignored.
REQ-004 SHALL have parameter CNT_W, default 32: retired-instruction counter width.
REQ-005 SHALL have clock and reset: one clock; reset is synchronous and active-high.
REQ-006 SHALL provide these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  OPCODE_W  instruction-register opcode field.
- mem_ready  in  1  memory access complete this cycle.
- state  out  STATE_W  current state.
- pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a, branch  out  1 each  datapath controls.
- alu_src_b, alu_op, pc_src  out  2 each  datapath selects.
- instr_done  out  1  retire pulse.
- illegal_op  out  1  trap flag.
- retired  out  CNT_W  count of retired instructions.

Function
REQ-007 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, TRAP=12; codes 13-15 SHALL go to FETCH on the next cycle.
REQ-008 SHALL decode opcodes as follows: LW=6'h23, SW=6'h2B, RTYPE=6'h00, BEQ=6'h04, ADDI=6'h08, J=6'h02.
REQ-009 SHALL sample opcode only in DECODE; it is don't-care in all other states.
REQ-010 SHALL make these transitions:
- FETCH->DECODE.
- DECODE->MEMADR (LW/SW), RTEX, BEQEX, ADDIEX, JEX; any other opcode->TRAP.
- MEMADR->MEMRD (LW) or MEMWR (SW).
- MEMRD->MEMWB.
- RTEX->RTWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTWB, BEQEX, ADDIWB, JEX->FETCH.
REQ-011 SHALL make MEMADR use the opcode held in a 1-bit is_store register captured in DECODE, not the live opcode.
REQ-012 SHALL, when USE_MEM_READY=1, hold FETCH, MEMRD and MEMWR while mem_ready=0, and advance on the cycle mem_ready=1.
REQ-013 SHALL keep mem_read asserted during a FETCH/MEMRD hold; pc_write, ir_write and mem_write SHALL be asserted only on the advancing cycle.
REQ-014 SHALL drive control outputs as a Moore function of state, gated only by REQ-013; unlisted outputs are 0 in each state:
- FETCH: mem_read, ir_write, pc_write, alu_src_b=01.
- DECODE: alu_src_b=11.
- MEMADR: alu_src_a, alu_src_b=10.
- MEMRD: mem_read, iord.
- MEMWB: reg_write, mem_to_reg.
- MEMWR: mem_write, iord.
- RTEX: alu_src_a, alu_op=10.
- RTWB: reg_write, reg_dst.
- BEQEX: alu_src_a, alu_op=01, branch, pc_src=01.
- ADDIEX: alu_src_a, alu_src_b=10.
- ADDIWB: reg_write.
- JEX: pc_write, pc_src=10.
- TRAP: all 0.
REQ-015 SHALL pulse instr_done for exactly one cycle on each transition from a final state to FETCH, and SHALL increment retired on that same edge.
REQ-016 SHALL let retired wrap modulo 2^CNT_W.
REQ-017 SHALL hold TRAP with illegal_op=1 until rst; instr_done SHALL NOT pulse for an illegal opcode.
REQ-018 SHALL take one cycle per state with no added latency; LW=5, SW=4, RTYPE=4, ADDI=4, BEQ=3, J=3 cycles with zero wait states.

Reset
REQ-019 SHALL, on rst=1 at a clk edge, set state=FETCH, retired=0, illegal_op=0, instr_done=0 and is_store=0.
REQ-020 SHALL give rst priority over all transitions, including mid-instruction, mid-wait and TRAP.
REQ-021 SHALL hold control outputs at their FETCH values with pc_write=ir_write=0 during the rst cycle.

Structure
REQ-022 SHALL place state codes, opcode constants and ALU-op/select encodings in shared package mc_pkg, reused by the datapath and ALU decoder.
REQ-023 SHALL put the per-state output table in sub-module mc_ctrl_decode (state in, controls out); the next-state logic, is_store register, counter and wait gating SHALL stay in the top module.

Verification
REQ-024 SHALL reset and then run LW 6'h23 with mem_ready=1 -> states 0,1,2,3,4,0; instr_done high in cycle 5; retired=1.
REQ-025 SHALL run SW 6'h2B with mem_ready low for 3 cycles in MEMWR -> state 5 held 3 cycles with mem_write=0, then mem_write=1 for one cycle, then FETCH.
REQ-026 SHALL decode opcode 6'h3F -> TRAP (12), illegal_op=1, held for 10 cycles; then rst -> FETCH, illegal_op=0.
REQ-027 SHALL run BEQ then J back-to-back -> 3+3 cycles, pc_src=01 then 10, retired=2.
REQ-028 SHALL assert rst during RTEX -> next state FETCH, retired unchanged at 0, no reg_write pulse.
REQ-029 SHALL, with CNT_W=4, retire 17 ADDI instructions -> retired=1 (wrap), with USE_MEM_READY=0 and mem_ready tied 0 causing no stalls.
